// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioner.
//   Synchronises the asynchronous pin, rejects contact bounce with a
//   counter-qualified four-state FSM, and produces a debounced level, a
//   one-cycle press pulse (the downstream latch enable), an optional
//   one-cycle release pulse and a modulo-256 press counter.
//   Optional feature macro: BTN_RELEASE_PULSE_EN
//     defined   -> btn_release pulses on every accepted falling edge
//     undefined -> btn_release is tied low and its register is not built
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [7:0] press_count
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HELD   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic [7:0]             press_count_q;
`ifdef BTN_RELEASE_PULSE_EN
    logic                   release_q;
`endif

    // Shift the raw pin through the synchroniser chain; only the last stage is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Debounce FSM with its qualification counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            level_q       <= 1'b0;
            press_q       <= 1'b0;
            press_count_q <= 8'd0;
`ifdef BTN_RELEASE_PULSE_EN
            release_q     <= 1'b0;
`endif
        end else begin
            // Pulses default low so they last exactly one cycle.
            press_q <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            release_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (btn_sync) begin
                        state_q <= CHK_HI;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CHK_HI: begin
                    if (!btn_sync) begin
                        // Bounce: abandon the qualification silently.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= HELD;
                        cnt_q         <= '0;
                        level_q       <= 1'b1;
                        press_q       <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    cnt_q <= '0;
                    if (!btn_sync) begin
                        state_q <= CHK_LO;
                    end else begin
                        state_q <= HELD;
                    end
                end
                CHK_LO: begin
                    if (btn_sync) begin
                        // Bounce: abandon the qualification silently.
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                        release_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign press_count = press_count_q;
`ifdef BTN_RELEASE_PULSE_EN
    assign btn_release = release_q;
`else
    assign btn_release = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A run-length reference model predicts every output each cycle; directed
// scenarios add hand-computed literal checks, then a randomized phase follows.
// Honours BTN_RELEASE_PULSE_EN the same way as the design.
module tb_btn_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

`ifdef BTN_RELEASE_PULSE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic [7:0] press_count;

    btn_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared = n_compared + 1;
        if (act !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The button is accepted as changed once the synchronised input has
    // differed from the debounced level for DEB+1 consecutive samples.
    typedef struct packed {
        logic        level;
        logic        press;
        logic        rel;
        logic [7:0]  count;
        logic [31:0] run;
    } model_t;

    localparam model_t M_RESET = '{level: 1'b0, press: 1'b0, rel: 1'b0, count: 8'd0, run: 32'd0};

    function automatic model_t model_step(model_t m, logic s);
        model_t n = m;
        n.press = 1'b0;
        n.rel   = 1'b0;
        if (s != m.level) begin
            n.run = m.run + 32'd1;
            if (n.run == 32'(DEB + 1)) begin
                n.level = s;
                n.run   = 32'd0;
                if (s) begin
                    n.press = 1'b1;
                    n.count = m.count + 8'd1;
                end else begin
                    n.rel = 1'b1;
                end
            end
        end else begin
            n.run = 32'd0;
        end
        return n;
    endfunction

    model_t          mdl  = M_RESET;
    logic [SYNC-1:0] hist = '0;   // raw pin as seen SYNC edges ago is hist[SYNC-1]

    // Advance the model on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mdl  <= M_RESET;
            hist <= '0;
        end else begin
            mdl  <= model_step(mdl, hist[SYNC-1]);
            hist <= {hist[SYNC-2:0], btn_raw};
        end
    end

    // Compare every output against the model on each falling edge.
    bit check_en = 1'b0;
    always @(negedge clk) begin
        if (check_en) begin
            chk("level",       {7'd0, btn_level},   {7'd0, mdl.level});
            chk("press",       {7'd0, btn_press},   {7'd0, mdl.press});
            chk("release",     {7'd0, btn_release}, {7'd0, mdl.rel & REL_EN});
            chk("press_count", press_count,         mdl.count);
            if (btn_press && btn_release) begin
                chk("press_and_release_together", 8'd1, 8'd0);
            end
        end
    end

    // Count press pulses seen while the window is open.
    bit count_win   = 1'b0;
    int press_seen  = 0;
    always @(negedge clk) begin
        if (count_win && btn_press) begin
            press_seen <= press_seen + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b0;
        step(3);
        rst      = 1'b0;
        check_en = 1'b1;

        // Reset state
        chk("rst_level", {7'd0, btn_level}, 8'd0);
        chk("rst_press", {7'd0, btn_press}, 8'd0);
        chk("rst_release", {7'd0, btn_release}, 8'd0);
        chk("rst_count", press_count, 8'd0);

        // Clean press: level/press after edge 7, press gone after edge 8
        btn_raw = 1'b1;
        step(6);
        chk("s1_press_edge6", {7'd0, btn_press}, 8'd0);
        step(1);
        chk("s1_level_edge7", {7'd0, btn_level}, 8'd1);
        chk("s1_press_edge7", {7'd0, btn_press}, 8'd1);
        chk("s1_count_edge7", press_count, 8'd1);
        chk("s1_model_press", {7'd0, mdl.press}, 8'd1);
        chk("s1_model_count", mdl.count, 8'd1);
        step(1);
        chk("s1_press_edge8", {7'd0, btn_press}, 8'd0);

        // Release 7 edges after the pin falls
        btn_raw = 1'b0;
        step(6);
        chk("s3_level_edge6", {7'd0, btn_level}, 8'd1);
        step(1);
        chk("s3_level_edge7", {7'd0, btn_level}, 8'd0);
        chk("s3_release_edge7", {7'd0, btn_release}, {7'd0, REL_EN});
        chk("s3_model_level", {7'd0, mdl.level}, 8'd0);
        step(1);
        chk("s3_release_edge8", {7'd0, btn_release}, 8'd0);

        // Bounce: high 2, low 1, then steady high
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        step(1);
        btn_raw = 1'b1;
        step(6);
        chk("s2_press_early", {7'd0, btn_press}, 8'd0);
        step(1);
        chk("s2_press", {7'd0, btn_press}, 8'd1);
        chk("s2_count", press_count, 8'd2);
        btn_raw = 1'b0;
        step(10);

        // Reset mid-qualification (CHK_HI with cnt=2)
        btn_raw = 1'b1;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("s4_level", {7'd0, btn_level}, 8'd0);
        chk("s4_press", {7'd0, btn_press}, 8'd0);
        chk("s4_count", press_count, 8'd0);
        step(6);
        chk("s4_press_early", {7'd0, btn_press}, 8'd0);
        step(1);
        chk("s4_press", {7'd0, btn_press}, 8'd1);
        chk("s4_count_after", press_count, 8'd1);
        btn_raw = 1'b0;
        step(10);

        // Counter wrap: 256 clean presses from zero
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        count_win = 1'b1;
        for (int i = 0; i < 256; i++) begin
            btn_raw = 1'b1;
            step(7);
            if (i == 254) begin
                chk("s5_count_255", press_count, 8'd255);
            end
            btn_raw = 1'b0;
            step(7);
        end
        count_win = 1'b0;
        chk("s5_count_wrap", press_count, 8'd0);
        chk("s5_pulses", press_seen[7:0], 8'd0);
        chk("s5_pulses_hi", 8'(press_seen >> 8), 8'd1);
        step(4);

        // Randomized segments with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            btn_raw = 1'($urandom_range(0, 1));
            step(int'($urandom_range(1, 9)));
        end
        btn_raw = 1'b0;
        step(12);
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
